// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolution-side partner of the fetch-stage branch predictor. Predictions
// issued at fetch are queued in order. Each outcome from execute is checked
// against the oldest queued prediction. A wrong prediction raises a
// mispredict pulse with the correct redirect PC and squashes the whole queue.
// Every resolve also sends a taken/not-taken update that trains the
// predictor's counters.
//
// Optional build macro: BRANCH_RESOLVE_STATS_EN adds saturating 16-bit
// resolve and mispredict counters (stats_resolved, stats_mispred).
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   pred_valid      fetch presents a predicted branch
//   pred_taken      predicted direction
//   pred_target     predicted target (meaningful when pred_taken)
//   pred_fallthru   PC of the next sequential instruction
//   pred_ready      entry accepted when pred_valid & pred_ready
//   res_valid       execute resolves the oldest in-flight branch
//   res_taken       actual direction
//   res_target      actual target
//   mispredict      registered pulse, prediction was wrong
//   redirect_pc     correct PC, meaningful with mispredict
//   upd_valid       registered pulse, predictor training strobe
//   upd_taken       actual direction for predictor training
//   res_error       registered pulse, resolve arrived with an empty queue
//   occupancy       entries currently held
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pred_valid,
   input  logic                   pred_taken,
   input  logic [AW-1:0]          pred_target,
   input  logic [AW-1:0]          pred_fallthru,
   output logic                   pred_ready,
   input  logic                   res_valid,
   input  logic                   res_taken,
   input  logic [AW-1:0]          res_target,
   output logic                   mispredict,
   output logic [AW-1:0]          redirect_pc,
   output logic                   upd_valid,
   output logic                   upd_taken,
   output logic                   res_error,
`ifdef BRANCH_RESOLVE_STATS_EN
   output logic [15:0]            stats_resolved,
   output logic [15:0]            stats_mispred,
`endif
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   typedef enum logic {ST_RUN, ST_RECOVER} state_t;

   state_t state_reg, state_next;

   // Queue storage; not reset, contents are only meaningful between pointers.
   logic          taken_mem    [DEPTH];
   logic [AW-1:0] target_mem   [DEPTH];
   logic [AW-1:0] fallthru_mem [DEPTH];

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [PW:0] wr_ptr_reg, wr_ptr_next;
   logic [PW:0] rd_ptr_reg, rd_ptr_next;

   logic          mispredict_reg, upd_valid_reg, upd_taken_reg, res_error_reg;
   logic [AW-1:0] redirect_pc_reg;

   logic          empty, full;
   logic          push_req, pop, mis;
   logic          head_taken;
   logic [AW-1:0] head_target, head_fallthru;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                  (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);

   assign head_taken    = taken_mem[rd_ptr_reg[PW-1:0]];
   assign head_target   = target_mem[rd_ptr_reg[PW-1:0]];
   assign head_fallthru = fallthru_mem[rd_ptr_reg[PW-1:0]];

   assign push_req = pred_valid & pred_ready;
   assign pop      = res_valid & ~empty;
   // Wrong direction, or right "taken" direction with the wrong target.
   assign mis      = pop & ((res_taken != head_taken) |
                            (res_taken & head_taken & (res_target != head_target)));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= ST_RUN;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      pred_ready = 1'b0;
      case (state_reg)
         ST_RUN: begin
            pred_ready = ~full;
            if (mis) state_next = ST_RECOVER;
         end
         ST_RECOVER: begin
            // One dead cycle lets fetch redirect before new pushes arrive.
            pred_ready = 1'b0;
            state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase
   end

   // ---------------- Pointers ----------------
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      // A push alongside a mispredict is wrong-path and is dropped.
      if (push_req && !mis) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      // Mispredict squashes everything younger than the head as well.
      if (mis)      rd_ptr_next = wr_ptr_reg;
      else if (pop) rd_ptr_next = rd_ptr_reg + PTR_ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_req && !mis) begin
         taken_mem[wr_ptr_reg[PW-1:0]]    <= pred_taken;
         target_mem[wr_ptr_reg[PW-1:0]]   <= pred_target;
         fallthru_mem[wr_ptr_reg[PW-1:0]] <= pred_fallthru;
      end
   end

   // ---------------- Registered results ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mispredict_reg  <= 1'b0;
         upd_valid_reg   <= 1'b0;
         upd_taken_reg   <= 1'b0;
         res_error_reg   <= 1'b0;
         redirect_pc_reg <= '0;
      end else begin
         mispredict_reg <= mis;
         upd_valid_reg  <= pop;
         res_error_reg  <= res_valid & empty;
         if (pop) begin
            upd_taken_reg   <= res_taken;
            redirect_pc_reg <= res_taken ? res_target : head_fallthru;
         end
      end
   end

   assign mispredict  = mispredict_reg;
   assign upd_valid   = upd_valid_reg;
   assign upd_taken   = upd_taken_reg;
   assign res_error   = res_error_reg;
   assign redirect_pc = redirect_pc_reg;
   assign occupancy   = wr_ptr_reg - rd_ptr_reg;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [15:0] stats_resolved_reg, stats_mispred_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stats_resolved_reg <= '0;
         stats_mispred_reg  <= '0;
      end else begin
         if (pop && stats_resolved_reg != 16'hFFFF)
            stats_resolved_reg <= stats_resolved_reg + 16'd1;
         if (mis && stats_mispred_reg != 16'hFFFF)
            stats_mispred_reg <= stats_mispred_reg + 16'd1;
      end
   end

   assign stats_resolved = stats_resolved_reg;
   assign stats_mispred  = stats_mispred_reg;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (DEPTH=4, AW=32).
// Each vector is one clock cycle of stimulus plus the outputs expected just
// after that cycle's edge. Expected records go into a scoreboard queue when
// driven and are popped and compared once the edge has passed.
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          pred_valid, pred_taken;
   logic [AW-1:0] pred_target, pred_fallthru;
   logic          pred_ready;
   logic          res_valid, res_taken;
   logic [AW-1:0] res_target;
   logic          mispredict;
   logic [AW-1:0] redirect_pc;
   logic          upd_valid, upd_taken, res_error;
   logic [2:0]    occupancy;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [15:0]   stats_resolved, stats_mispred;
`endif

   branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .pred_valid    (pred_valid),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_fallthru (pred_fallthru),
      .pred_ready    (pred_ready),
      .res_valid     (res_valid),
      .res_taken     (res_taken),
      .res_target    (res_target),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc),
      .upd_valid     (upd_valid),
      .upd_taken     (upd_taken),
      .res_error     (res_error),
`ifdef BRANCH_RESOLVE_STATS_EN
      .stats_resolved(stats_resolved),
      .stats_mispred (stats_mispred),
`endif
      .occupancy     (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pv;
      logic        pt;
      logic [31:0] ptg;
      logic [31:0] pf;
      logic        rv;
      logic        rt;
      logic [31:0] rtg;
      logic        e_mis;
      logic [31:0] e_rpc;
      logic        e_upd;
      logic        e_ut;
      logic        e_err;
      int          e_occ;
      logic        e_rdy;
   } vec_t;

   vec_t vq[$];
   vec_t sb[$];
   int   tests = 0;
   int   failed = 0;
   int   txn = 0;
   int   n_res = 0;
   int   n_mis = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic pv, input logic pt, input logic [31:0] ptg,
                      input logic [31:0] pf, input logic rv, input logic rt,
                      input logic [31:0] rtg, input logic e_mis, input logic [31:0] e_rpc,
                      input logic e_upd, input logic e_ut, input logic e_err,
                      input int e_occ, input logic e_rdy);
      vec_t v;
      v.pv = pv; v.pt = pt; v.ptg = ptg; v.pf = pf;
      v.rv = rv; v.rt = rt; v.rtg = rtg;
      v.e_mis = e_mis; v.e_rpc = e_rpc; v.e_upd = e_upd; v.e_ut = e_ut;
      v.e_err = e_err; v.e_occ = e_occ; v.e_rdy = e_rdy;
      vq.push_back(v);
   endtask

   // Drive one vector (called just after an active edge), wait for the next
   // edge, then pop the scoreboard and compare.
   task automatic run_vec(input vec_t v);
      vec_t e;
      pred_valid = v.pv; pred_taken = v.pt; pred_target = v.ptg; pred_fallthru = v.pf;
      res_valid = v.rv; res_taken = v.rt; res_target = v.rtg;
      sb.push_back(v);
      if (v.e_upd) n_res++;
      if (v.e_mis) n_mis++;
      @(posedge clk);
      #1;
      pred_valid = 1'b0; res_valid = 1'b0;
      e = sb.pop_front();
      check($sformatf("t%0d mispredict", txn), {31'd0, mispredict}, {31'd0, e.e_mis});
      if (e.e_mis)
         check($sformatf("t%0d redirect_pc", txn), redirect_pc, e.e_rpc);
      check($sformatf("t%0d upd_valid", txn), {31'd0, upd_valid}, {31'd0, e.e_upd});
      if (e.e_upd)
         check($sformatf("t%0d upd_taken", txn), {31'd0, upd_taken}, {31'd0, e.e_ut});
      check($sformatf("t%0d res_error", txn), {31'd0, res_error}, {31'd0, e.e_err});
      check($sformatf("t%0d occupancy", txn), {29'd0, occupancy}, e.e_occ);
      check($sformatf("t%0d pred_ready", txn), {31'd0, pred_ready}, {31'd0, e.e_rdy});
      $display("[TB] txn %0d: pv=%0b rv=%0b -> mis=%0b rpc=%0h upd=%0b/%0b err=%0b occ=%0d rdy=%0b",
               txn, e.pv, e.rv, mispredict, redirect_pc, upd_valid, upd_taken,
               res_error, occupancy, pred_ready);
      txn++;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " mispredict"},  {31'd0, mispredict}, 32'd0);
      check({tag, " upd_valid"},   {31'd0, upd_valid},  32'd0);
      check({tag, " upd_taken"},   {31'd0, upd_taken},  32'd0);
      check({tag, " res_error"},   {31'd0, res_error},  32'd0);
      check({tag, " redirect_pc"}, redirect_pc,         32'd0);
      check({tag, " occupancy"},   {29'd0, occupancy},  32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      pred_valid = 0; pred_taken = 0; pred_target = 0; pred_fallthru = 0;
      res_valid = 0; res_taken = 0; res_target = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check_idle_outputs("reset");
      check("reset pred_ready", {31'd0, pred_ready}, 32'd1);

      //   pv pt ptg     pf       rv rt rtg     mis rpc     upd ut err occ rdy
      // fill to DEPTH, fifth push refused
      add(1, 1, 'h10,  'h04,  0, 0, 0,      0, 0,      0, 0, 0, 1, 1);
      add(1, 0, 'h0,   'h08,  0, 0, 0,      0, 0,      0, 0, 0, 2, 1);
      add(1, 1, 'h20,  'h0c,  0, 0, 0,      0, 0,      0, 0, 0, 3, 1);
      add(1, 0, 'h0,   'h14,  0, 0, 0,      0, 0,      0, 0, 0, 4, 0);
      add(1, 1, 'h99,  'h98,  0, 0, 0,      0, 0,      0, 0, 0, 4, 0);
      // correct resolves draining, one with a simultaneous push
      add(0, 0, 0,     0,     1, 1, 'h10,   0, 0,      1, 1, 0, 3, 1);
      add(0, 0, 0,     0,     1, 0, 'h55,   0, 0,      1, 0, 0, 2, 1);
      add(1, 1, 'h100, 'h24,  1, 1, 'h20,   0, 0,      1, 1, 0, 2, 1);
      add(0, 0, 0,     0,     1, 0, 0,      0, 0,      1, 0, 0, 1, 1);
      add(0, 0, 0,     0,     1, 1, 'h100,  0, 0,      1, 1, 0, 0, 1);
      // direction mispredict squashes younger entries, then one RECOVER cycle
      add(1, 0, 0,     'h44,  0, 0, 0,      0, 0,      0, 0, 0, 1, 1);
      add(1, 1, 'h50,  'h48,  0, 0, 0,      0, 0,      0, 0, 0, 2, 1);
      add(1, 0, 0,     'h4c,  0, 0, 0,      0, 0,      0, 0, 0, 3, 1);
      add(0, 0, 0,     0,     1, 1, 'h200,  1, 'h200,  1, 1, 0, 0, 0);
      add(1, 1, 'h11,  'h12,  0, 0, 0,      0, 0,      0, 0, 0, 0, 1);
      // target mispredict, then taken-predicted but not taken
      add(1, 1, 'h300, 'h30,  0, 0, 0,      0, 0,      0, 0, 0, 1, 1);
      add(0, 0, 0,     0,     1, 1, 'h304,  1, 'h304,  1, 1, 0, 0, 0);
      add(0, 0, 0,     0,     0, 0, 0,      0, 0,      0, 0, 0, 0, 1);
      add(1, 1, 'h80,  'h60,  0, 0, 0,      0, 0,      0, 0, 0, 1, 1);
      add(0, 0, 0,     0,     1, 0, 0,      1, 'h60,   1, 0, 0, 0, 0);
      add(0, 0, 0,     0,     0, 0, 0,      0, 0,      0, 0, 0, 0, 1);
      // resolve on empty queue with simultaneous push
      add(1, 0, 0,     'h90,  1, 1, 'h77,   0, 0,      0, 0, 1, 1, 1);
      add(0, 0, 0,     0,     1, 0, 0,      0, 0,      1, 0, 0, 0, 1);
      // push in the same cycle as a mispredict is dropped
      add(1, 1, 'ha0,  'ha4,  0, 0, 0,      0, 0,      0, 0, 0, 1, 1);
      add(1, 0, 0,     'hb0,  1, 0, 0,      1, 'ha4,   1, 0, 0, 0, 0);
      add(0, 0, 0,     0,     0, 0, 0,      0, 0,      0, 0, 0, 0, 1);

      for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

`ifdef BRANCH_RESOLVE_STATS_EN
      check("stats_resolved", {16'd0, stats_resolved}, n_res);
      check("stats_mispred",  {16'd0, stats_mispred},  n_mis);
`endif

      // Hand sequence: three entries, mispredict, reset during RECOVER.
      vq.delete();
      add(1, 1, 'h10, 'h14, 0, 0, 0, 0, 0,     0, 0, 0, 1, 1);
      add(1, 0, 0,    'h18, 0, 0, 0, 0, 0,     0, 0, 0, 2, 1);
      add(1, 1, 'h40, 'h1c, 0, 0, 0, 0, 0,     0, 0, 0, 3, 1);
      add(0, 0, 0,    0,    1, 0, 0, 1, 'h14,  1, 0, 0, 0, 0);
      for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);
      #2 reset = 1'b1;
      #1;
      check_idle_outputs("mid-recover reset");
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check_idle_outputs("after release");
      check("after release pred_ready", {31'd0, pred_ready}, 32'd1);
`ifdef BRANCH_RESOLVE_STATS_EN
      check("reset stats_resolved", {16'd0, stats_resolved}, 32'd0);
      check("reset stats_mispred",  {16'd0, stats_mispred},  32'd0);
`endif
      @(posedge clk);
      #1;
      vq.delete();
      add(1, 1, 'h500, 'h504, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0,     0,     1, 1, 'h500, 0, 0, 1, 1, 0, 0, 1);
      for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
